// File: rtl/multiword_add_seq_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the multi-word sequential adder and its word slice.
//   WORD_W        : width of one adder word (32, matches the slice)
//   word_t        : one adder word
//   mwadd_state_e : sequencer states (IDLE, ADD, DONE)
// ---------------------------------------------------------------------------
package adder_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } mwadd_state_e;

endpackage : adder_pkg

// File: rtl/multiword_add_seq_if.sv
// ---------------------------------------------------------------------------
// multiword_add_seq_if
// Operand and result handshakes of the multi-word adder.
//   in_valid/in_ready     : operand handshake (in_a, in_b, in_cin[, in_sub])
//   out_valid/out_ready   : result handshake (out_sum, out_cout)
// Modports: master = operand source / result sink, slave = adder.
// Optional macro MULTIWORD_ADD_SUB_EN adds the in_sub operand bit.
// ---------------------------------------------------------------------------
interface multiword_add_seq_if
   import adder_pkg::*;
#(
   parameter int NWORDS = 4
);
   logic                       in_valid;
   logic                       in_ready;
   logic [NWORDS*WORD_W-1:0]   in_a;
   logic [NWORDS*WORD_W-1:0]   in_b;
   logic                       in_cin;
`ifdef MULTIWORD_ADD_SUB_EN
   logic                       in_sub;
`endif
   logic                       out_valid;
   logic                       out_ready;
   logic [NWORDS*WORD_W-1:0]   out_sum;
   logic                       out_cout;

   modport master (
      output in_valid, in_a, in_b, in_cin,
`ifdef MULTIWORD_ADD_SUB_EN
      output in_sub,
`endif
      output out_ready,
      input  in_ready, out_valid, out_sum, out_cout
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin,
`ifdef MULTIWORD_ADD_SUB_EN
      input  in_sub,
`endif
      input  out_ready,
      output in_ready, out_valid, out_sum, out_cout
   );

endinterface : multiword_add_seq_if

// File: rtl/multiword_add_seq_slice.sv
// ---------------------------------------------------------------------------
// add32_slice
// Combinational one-word unsigned adder: {cout, sum} = a + b + cin.
//   a, b : word operands
//   cin  : carry in
//   sum  : word sum
//   cout : carry out of the word
// ---------------------------------------------------------------------------
module add32_slice
   import adder_pkg::*;
(
   input  word_t a,
   input  word_t b,
   input  logic  cin,
   output word_t sum,
   output logic  cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};

endmodule : add32_slice

// File: rtl/multiword_add_seq.sv
// ---------------------------------------------------------------------------
// multiword_add_seq
// Sequential multi-word unsigned adder. Operands are captured on the input
// handshake, then one word per cycle (LSW first) is pushed through a single
// add32_slice with the carry fed back. The full sum and final carry are held
// on the output handshake until accepted.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : multiword_add_seq_if.slave (operand and result handshakes)
// Optional macro MULTIWORD_ADD_SUB_EN: in_sub=1 computes A-B (B inverted,
// word-0 carry forced to 1); out_cout=1 then means no borrow.
// ---------------------------------------------------------------------------
module multiword_add_seq
   import adder_pkg::*;
#(
   parameter int NWORDS = 4,
   parameter int WORD_W = 32
)
(
   input  logic                clk,
   input  logic                rst,
   multiword_add_seq_if.slave  bus
);

   localparam int               IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   mwadd_state_e     state_reg, state_next;
   logic [IDX_W-1:0] idx_reg;
   logic             carry_reg;
   logic             accept;

   word_t a_reg   [NWORDS];
   word_t b_reg   [NWORDS];
   word_t sum_reg [NWORDS];

   word_t slice_a, slice_b, slice_sum;
   logic  slice_cout;
   logic  cin_first;

`ifdef MULTIWORD_ADD_SUB_EN
   logic sub_reg;

   // Subtraction is A + ~B + 1: the +1 enters as the word-0 carry.
   assign cin_first = bus.in_sub ? 1'b1 : bus.in_cin;
   assign slice_b   = sub_reg ? ~b_reg[idx_reg] : b_reg[idx_reg];

   always_ff @(posedge clk) begin
      if (rst) begin
         sub_reg <= 1'b0;
      end else if (accept) begin
         sub_reg <= bus.in_sub;
      end
   end
`else
   assign cin_first = bus.in_cin;
   assign slice_b   = b_reg[idx_reg];
`endif

   assign slice_a = a_reg[idx_reg];

   add32_slice u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_reg),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Next-state and handshake outputs.
   always_comb begin
      state_next    = state_reg;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_reg)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_next = ADD;
         end
         ADD: begin
            if (idx_reg == LAST_IDX) state_next = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            // A new operand set may be taken on the same edge the result leaves.
            bus.in_ready  = bus.out_ready;
            if (bus.out_ready) state_next = bus.in_valid ? ADD : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            idx_reg   <= '0;
            carry_reg <= cin_first;
         end else if (state_reg == ADD) begin
            idx_reg   <= idx_reg + 1'b1;
            carry_reg <= slice_cout;
         end
      end
   end

   // Per-word operand and result storage; the result words drive out_sum directly.
   for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
      always_ff @(posedge clk) begin
         if (rst) begin
            a_reg[gi]   <= '0;
            b_reg[gi]   <= '0;
            sum_reg[gi] <= '0;
         end else begin
            if (accept) begin
               a_reg[gi] <= bus.in_a[gi*WORD_W +: WORD_W];
               b_reg[gi] <= bus.in_b[gi*WORD_W +: WORD_W];
            end
            if (state_reg == ADD && idx_reg == IDX_W'(gi)) begin
               sum_reg[gi] <= slice_sum;
            end
         end
      end
      assign bus.out_sum[gi*WORD_W +: WORD_W] = sum_reg[gi];
   end

   // After the last word the carry register holds the final carry out.
   assign bus.out_cout = carry_reg;

endmodule : multiword_add_seq
